// File: rtl/wfifo_drain_pkg.sv
// Shared types and constants for the write-data drain stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wfifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_ARMED    = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int WORD_W = 16;
    localparam int STRB_W = 2;

    // Byte lanes: the high byte goes out on the CK rising edge.
    localparam int RISE_MSB  = 15;
    localparam int RISE_LSB  = 8;
    localparam int FALL_MSB  = 7;
    localparam int FALL_LSB  = 0;
    localparam int STRB_RISE = 1;
    localparam int STRB_FALL = 0;

    // What the DQ/RWDS cells see for a word that must not be written.
    localparam logic [WORD_W-1:0] MASKED_DQ   = 16'h0000;
    localparam logic [STRB_W-1:0] MASKED_RWDS = 2'b11;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } entry_t;

    // RWDS is a write mask: a set strobe means "write", i.e. RWDS low.
    function automatic logic [STRB_W-1:0] strb_to_rwds(input logic [STRB_W-1:0] strb);
        return ~strb;
    endfunction

endpackage

// File: rtl/wfifo_drain_pipe.sv
// FIFO-pop-to-hold-register pipeline with a 2-entry skid buffer.
// Latency: word at the head 2 cycles after the pop (1 FIFO read + 1 capture).
// Backpressure: pops only while buffered + in-flight words stay below 2 and budget remains.
// Ports: start/start_len load the per-burst pop budget; flush drops all buffered and
// in-flight words; enable gates popping; take consumes the head entry;
// fifo_rd_* is the standard (non-FWFT) FIFO read port; head/head_vld expose the oldest word.
module wfifo_drain_pipe
    import wfifo_drain_pkg::*;
#(
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [LEN_W-1:0] start_len,
    input  logic             flush,
    input  logic             enable,
    input  logic             take,
    input  logic [15:0]      fifo_rd_dout,
    input  logic [1:0]       fifo_rd_strb,
    input  logic             fifo_rd_empty,
    output logic             fifo_rd_en,
    output logic             head_vld,
    output entry_t           head
);

    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    entry_t           slot0;
    entry_t           slot1;
    entry_t           landing;
    logic [1:0]       occ;
    logic             inflight;
    logic [LEN_W-1:0] budget;
    logic             take_eff;
    logic [1:0]       occ_after_take;
    logic [2:0]       committed;

    assign head_vld = (occ != 2'd0);
    assign head     = slot0;
    assign landing  = '{data: fifo_rd_dout, strb: fifo_rd_strb};

    always_comb begin
        take_eff       = take && head_vld;
        occ_after_take = occ - {1'b0, take_eff};
        // Count the in-flight read so a word arriving next cycle always has a slot.
        committed      = {1'b0, occ_after_take} + {2'b00, inflight};
        fifo_rd_en     = enable && !fifo_rd_empty && (budget != '0) && (committed < 3'd2);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            budget   <= '0;
            slot0    <= '0;
            slot1    <= '0;
        end else begin
            if (start) begin
                budget <= start_len;
            end else if (fifo_rd_en) begin
                budget <= budget - LEN_ONE;
            end

            if (flush) begin
                occ      <= 2'd0;
                inflight <= 1'b0;
            end else begin
                inflight <= fifo_rd_en;
                occ      <= occ_after_take + {1'b0, inflight};
                if (take_eff) begin
                    slot0 <= slot1;
                end
                // The landing word goes behind whatever survives this cycle's take.
                if (inflight) begin
                    if (occ_after_take == 2'd0) begin
                        slot0 <= landing;
                    end else begin
                        slot1 <= landing;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wfifo_drain.sv
// Write-data drain: pops FIFO words and splits them into DDR rise/fall bytes with RWDS masks.
// Latency: first word on DQ the cycle after data_go (once prefetched); then one word per clk.
// Backpressure: cmd_ready only in IDLE; FIFO starvation masks the rest of the burst, never stalls.
// Ports: cmd_valid/cmd_ready/cmd_len take a burst; data_go starts the data phase;
// fifo_rd_* is the FIFO read port; dq_*/rwds_*/dq_oe feed the output DDR cells;
// busy/done report progress; underrun is a sticky error cleared by err_clr.
module wfifo_drain
    import wfifo_drain_pkg::*;
#(
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             data_go,
    input  logic [15:0]      fifo_rd_dout,
    input  logic [1:0]       fifo_rd_strb,
    output logic             fifo_rd_en,
    input  logic             fifo_rd_empty,
    output logic [7:0]       dq_rise,
    output logic [7:0]       dq_fall,
    output logic             rwds_rise,
    output logic             rwds_fall,
    output logic             dq_oe,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    input  logic             err_clr
);

    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    state_t           state;
    state_t           state_n;
    logic [LEN_W-1:0] remaining;
    logic             go_seen;
    logic             burst_ur;
    logic             accept;
    logic             load;
    logic             masked;
    logic             take;
    logic             ur_now;
    logic             pipe_en;
    logic             flush;
    logic             head_vld;
    entry_t           head;
    logic [1:0]       rwds_word;

    wfifo_drain_pipe #(.LEN_W(LEN_W)) u_pipe (
        .clk          (clk),
        .arst         (arst),
        .start        (accept),
        .start_len    (cmd_len),
        .flush        (flush),
        .enable       (pipe_en),
        .take         (take),
        .fifo_rd_dout (fifo_rd_dout),
        .fifo_rd_strb (fifo_rd_strb),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_en   (fifo_rd_en),
        .head_vld     (head_vld),
        .head         (head)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rwds_word = strb_to_rwds(head.strb);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        load    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_len != '0) state_n = ST_PREFETCH;
                end
            end
            ST_PREFETCH: if (head_vld) state_n = ST_ARMED;
            ST_ARMED: begin
                if (data_go || go_seen) begin
                    load    = 1'b1;
                    state_n = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // remaining counts words not yet loaded into the output register.
                if (remaining != '0) load = 1'b1;
                else                 state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        // An empty head at a load slot means the FIFO was empty when this word was due.
        masked  = burst_ur || !head_vld;
        take    = load && !masked;
        ur_now  = load && !burst_ur && !head_vld;
        pipe_en = ((state == ST_PREFETCH) || (state == ST_ARMED) || (state == ST_STREAM))
                  && !burst_ur && !ur_now;
        // Late words that land after an underrun must not leak into the next burst.
        flush   = (state == ST_IDLE) || (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            go_seen   <= 1'b0;
            burst_ur  <= 1'b0;
            dq_rise   <= 8'h00;
            dq_fall   <= 8'h00;
            rwds_rise <= 1'b1;
            rwds_fall <= 1'b1;
            dq_oe     <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state <= state_n;

            if (accept)    remaining <= cmd_len;
            else if (load) remaining <= remaining - LEN_ONE;

            // go may arrive with the command or during prefetch; hold it until used.
            if (state == ST_IDLE)  go_seen <= accept && (cmd_len != '0) && data_go;
            else if (load)         go_seen <= 1'b0;
            else if (data_go)      go_seen <= 1'b1;

            if (accept)      burst_ur <= 1'b0;
            else if (ur_now) burst_ur <= 1'b1;

            if (ur_now)       underrun <= 1'b1;
            else if (err_clr) underrun <= 1'b0;

            done  <= ((state == ST_STREAM) && (remaining == '0)) || (accept && (cmd_len == '0));
            dq_oe <= load;

            if (take) begin
                dq_rise   <= head.data[RISE_MSB:RISE_LSB];
                dq_fall   <= head.data[FALL_MSB:FALL_LSB];
                rwds_rise <= rwds_word[STRB_RISE];
                rwds_fall <= rwds_word[STRB_FALL];
            end else begin
                dq_rise   <= MASKED_DQ[RISE_MSB:RISE_LSB];
                dq_fall   <= MASKED_DQ[FALL_MSB:FALL_LSB];
                rwds_rise <= MASKED_RWDS[STRB_RISE];
                rwds_fall <= MASKED_RWDS[STRB_FALL];
            end
        end
    end

endmodule

// File: tb/tb_wfifo_drain.sv
// Self-checking bench for wfifo_drain: FIFO model, directed cases and random bursts.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_wfifo_drain;

    localparam int LEN_W = 9;

    logic             clk = 1'b0;
    logic             arst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             data_go;
    logic [15:0]      fifo_rd_dout;
    logic [1:0]       fifo_rd_strb;
    logic             fifo_rd_en;
    logic             fifo_rd_empty;
    logic [7:0]       dq_rise;
    logic [7:0]       dq_fall;
    logic             rwds_rise;
    logic             rwds_fall;
    logic             dq_oe;
    logic             busy;
    logic             done;
    logic             underrun;
    logic             err_clr;

    wfifo_drain #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .arst         (arst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .data_go      (data_go),
        .fifo_rd_dout (fifo_rd_dout),
        .fifo_rd_strb (fifo_rd_strb),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_empty(fifo_rd_empty),
        .dq_rise      (dq_rise),
        .dq_fall      (dq_fall),
        .rwds_rise    (rwds_rise),
        .rwds_fall    (rwds_fall),
        .dq_oe        (dq_oe),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // FIFO contents and per-burst words, each {data[15:0], strb[1:0]}.
    logic [17:0] fq[$];
    logic [17:0] wq[$];
    // Observed output words, each {dq_rise, dq_fall, rwds_rise, rwds_fall}.
    logic [17:0] obs[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    int first_cyc, last_cyc, done_n, done_cyc, pops;
    bit pop_pend = 1'b0;
    bit rdy_smp;
    bit ur_model = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected DDR-cell drive for one burst word.
    function automatic logic [17:0] drive_of(input logic [17:0] w, input bit masked);
        if (masked) return {8'h00, 8'h00, 1'b1, 1'b1};
        return {w[17:10], w[9:2], ~w[1], ~w[0]};
    endfunction

    task automatic clear_mon();
        obs.delete();
        first_cyc = -1;
        last_cyc  = -1;
        done_n    = 0;
        done_cyc  = -1;
        pops      = 0;
    endtask

    // One clock: inputs already set by the caller, sample mid-cycle, model FIFO read at the edge.
    task automatic step();
        cyc_n++;
        fifo_rd_empty = (fq.size() == 0);
        @(negedge clk);
        rdy_smp = cmd_ready;
        if (dq_oe) begin
            obs.push_back({dq_rise, dq_fall, rwds_rise, rwds_fall});
            if (first_cyc < 0) first_cyc = cyc_n;
            last_cyc = cyc_n;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc_n;
        end
        if (fifo_rd_en) pops++;
        pop_pend = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop_pend && fq.size() != 0) begin
            {fifo_rd_dout, fifo_rd_strb} = fq.pop_front();
        end
    endtask

    task automatic check_idle(input string pfx);
        chk({pfx, "_dq"}, {dq_rise, dq_fall}, 16'h0000);
        chk({pfx, "_rwds"}, {rwds_rise, rwds_fall}, 2'b11);
        chk({pfx, "_oe_done_busy_rden"}, {dq_oe, done, busy, fifo_rd_en}, 4'b0000);
        chk({pfx, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    task automatic run_burst(input int len, input int n, input int go_dly, input int fill_dly,
                             input int abort_at, input bit exact_first);
        int go_cyc = -1;
        int limit  = len + go_dly + fill_dly + 40;
        int t      = 0;
        int tail   = 0;
        int exp_pops;
        logic [17:0] w;
        clear_mon();
        while (t < limit && tail < 3) begin
            cmd_valid = (t == 0);
            cmd_len   = len[LEN_W-1:0];
            data_go   = (t == go_dly);
            if (t == go_dly) go_cyc = cyc_n + 1;
            if (t == fill_dly) foreach (wq[i]) fq.push_back(wq[i]);
            step();
            if (t == 0) chk("cmd_ready_at_accept", rdy_smp, 1'b1);
            if (done_n > 0) tail++;
            t++;
            if (abort_at != 0 && obs.size() == abort_at) begin
                cmd_valid = 1'b0;
                data_go   = 1'b0;
                arst      = 1'b1;
                #1;
                check_idle("abort");
                chk("abort_underrun", underrun, 1'b0);
                arst     = 1'b0;
                ur_model = 1'b0;
                pop_pend = 1'b0;
                fq.delete();
                return;
            end
        end
        cmd_valid = 1'b0;
        data_go   = 1'b0;
        chk("done_pulses", done_n, 1);
        chk("data_cycles", obs.size(), len);
        chk("contiguous", last_cyc - first_cyc + 1, obs.size());
        chk("done_after_last", done_cyc, last_cyc + 1);
        exp_pops = (n < len) ? n : len;
        chk("pops", pops, exp_pops);
        if (n < len) ur_model = 1'b1;
        chk("underrun", underrun, ur_model);
        if (exact_first) chk("first_latency", first_cyc, go_cyc + 1);
        else             chk("first_after_go", first_cyc > go_cyc, 1'b1);
        for (int i = 0; i < len && i < obs.size(); i++) begin
            if (i < n) w = wq[i];
            else       w = 18'h0;
            chk($sformatf("word%0d", i), obs[i], drive_of(w, i >= n));
        end
        fq.delete();
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(18'($urandom));
    endtask

    task automatic clear_error();
        err_clr = 1'b1;
        step();
        err_clr  = 1'b0;
        ur_model = 1'b0;
        chk("underrun_cleared", underrun, 1'b0);
    endtask

    initial begin
        int len, n, c0;
        arst          = 1'b1;
        cmd_valid     = 1'b0;
        cmd_len       = '0;
        data_go       = 1'b0;
        err_clr       = 1'b0;
        fifo_rd_dout  = 16'h0;
        fifo_rd_strb  = 2'b00;
        fifo_rd_empty = 1'b1;
        #12;
        check_idle("reset");
        chk("reset_underrun", underrun, 1'b0);
        arst = 1'b0;
        repeat (2) step();

        // Mapping of lanes and masks.
        wq.delete();
        wq.push_back({16'hA1B2, 2'b11});
        wq.push_back({16'hC3D4, 2'b10});
        wq.push_back({16'hE5F6, 2'b01});
        wq.push_back({16'h0718, 2'b00});
        run_burst(4, 4, 8, 0, 0, 1'b1);

        // Starved burst: one word for a length-3 burst.
        fill_random(1);
        run_burst(3, 1, 6, 0, 0, 1'b1);
        clear_error();

        // Zero-length command.
        clear_mon();
        cmd_valid = 1'b1;
        cmd_len   = '0;
        c0 = cyc_n + 1;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        chk("len0_done_cycle", done_cyc, c0 + 1);
        chk("len0_done_count", done_n, 1);
        chk("len0_pops", pops, 0);
        chk("len0_oe_cycles", obs.size(), 0);
        chk("len0_busy", busy, 1'b0);

        // go together with the command, FIFO filled later.
        fill_random(4);
        run_burst(4, 4, 0, 3, 0, 1'b0);

        // Maximum length, FIFO never runs dry.
        fill_random(511);
        run_burst(511, 511, 10, 0, 0, 1'b1);

        // Reset in the middle of a burst, then a clean short burst.
        fill_random(10);
        run_burst(10, 10, 8, 0, 5, 1'b0);
        repeat (2) step();
        fill_random(2);
        run_burst(2, 2, 6, 0, 0, 1'b1);

        // Random bursts: length, fill level, go timing and fill timing.
        for (int k = 0; k < 25; k++) begin
            len = $urandom_range(24, 1);
            n   = $urandom_range(len + 3, 1);
            fill_random(n);
            run_burst(len, n, $urandom_range(8, 0), $urandom_range(6, 0), 0, 1'b0);
            if ($urandom_range(1, 0) == 1) clear_error();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

endmodule
